// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu: operand and Hack control bits on the
// request side, result plus flags on the response side, each with valid/ready.
interface seq_alu_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             co;
    logic             ov;

    // Producer/consumer side (decode stage feeding, writeback draining).
    modport master (
        output in_valid, a, b, zx, nx, zy, ny, f, no, out_ready,
        input  in_ready, out_valid, out, zr, ng, co, ov
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, zx, nx, zy, ny, f, no, out_ready,
        output in_ready, out_valid, out, zr, ng, co, ov
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle Hack ALU. Operands are pre-conditioned (zero/invert) at accept,
// then the add walks a CHUNK-bit adder across WIDTH/CHUNK cycles with a
// registered carry. The AND path finishes in a single CALC cycle. Results,
// zr/ng and the add flags co/ov are held in DONE until the consumer takes them.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam int N   = WIDTH / CHUNK;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] sum_q;
    logic             f_q;
    logic             no_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;

    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic             co_q;
    logic             ov_q;

    logic             accept;
    logic             last;
    logic             finish;
    int               base;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] res_d;
    logic             ov_d;

    // Hack operand conditioning: optional zeroing, then optional inversion.
    function automatic logic [WIDTH-1:0] hack_pre(
        input logic [WIDTH-1:0] v,
        input logic             z,
        input logic             n
    );
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    assign accept = bus.in_valid && (state_q == IDLE);
    assign last   = (k_q == KW'(N - 1));
    // AND finishes in its first CALC cycle; the add on its final chunk.
    assign finish = (state_q == CALC) && (!f_q || last);

    // One CHUNK-bit slice of the add, merged into the partial sum.
    always_comb begin
        base      = int'(k_q) * CHUNK;
        chunk_sum = {1'b0, x_q[base +: CHUNK]} + {1'b0, y_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        sum_next  = sum_q;
        sum_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Final result and overflow, formed from the completed sum or x&y.
    always_comb begin
        res_d = '0;
        ov_d  = 1'b0;
        if (f_q) begin
            res_d = no_q ? ~sum_next : sum_next;
            ov_d  = (x_q[MSB] == y_q[MSB]) && (sum_next[MSB] != x_q[MSB]);
        end else begin
            res_d = no_q ? ~(x_q & y_q) : (x_q & y_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid)  state_d = CALC;
            CALC: if (!f_q || last)  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Conditioned operands and partial sum; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= hack_pre(bus.a, bus.zx, bus.nx);
            y_q <= hack_pre(bus.b, bus.zy, bus.ny);
        end
        if (state_q == CALC) begin
            sum_q <= sum_next;
        end
    end

    // Operation control: function select, chunk index and ripple carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 1'b0;
            no_q    <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            f_q     <= bus.f;
            no_q    <= bus.no;
            k_q     <= '0;
            carry_q <= 1'b0;
        end else if ((state_q == CALC) && f_q) begin
            carry_q <= chunk_sum[CHUNK];
            if (!last) begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // Result and flag registers, written once per operation and held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (finish) begin
            out_q <= res_d;
            zr_q  <= (res_d == '0);
            ng_q  <= res_d[MSB];
            co_q  <= f_q & chunk_sum[CHUNK];
            ov_q  <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.co        = co_q;
    assign bus.ov        = ov_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: three configurations (16/4, 32/8, 16/16) driven with
// directed and random requests; a cycle-level reference model predicts
// handshake behaviour and results from the Hack ALU rules.
module tb_seq_alu;

    logic            clk = 1'b0;
    logic [2:0]      rstn;
    logic [2:0]      iv;
    logic [2:0][31:0] ia;
    logic [2:0][31:0] ib;
    logic [2:0][5:0] ictl;   // {zx,nx,zy,ny,f,no}
    logic [2:0]      ordy;
    logic [2:0]      irdy;
    logic [2:0]      ovld;
    logic [2:0][31:0] oout;
    logic [2:0]      ozr, ong, oco, oov;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [2:0] pend = '0;
    int         acc[3];
    int         elat[3];
    logic [31:0] eo[3];
    logic [3:0]  ef[3];

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(16)) if0 ();
    seq_alu_if #(.WIDTH(32)) if1 ();
    seq_alu_if #(.WIDTH(16)) if2 ();

    seq_alu #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst_n(rstn[0]), .bus(if0));
    seq_alu #(.WIDTH(32), .CHUNK(8))  dut1 (.clk(clk), .rst_n(rstn[1]), .bus(if1));
    seq_alu #(.WIDTH(16), .CHUNK(16)) dut2 (.clk(clk), .rst_n(rstn[2]), .bus(if2));

    assign if0.in_valid = iv[0];  assign if0.a = ia[0][15:0]; assign if0.b = ib[0][15:0];
    assign if0.zx = ictl[0][5];   assign if0.nx = ictl[0][4]; assign if0.zy = ictl[0][3];
    assign if0.ny = ictl[0][2];   assign if0.f  = ictl[0][1]; assign if0.no = ictl[0][0];
    assign if0.out_ready = ordy[0];
    assign irdy[0] = if0.in_ready; assign ovld[0] = if0.out_valid; assign oout[0] = {16'd0, if0.out};
    assign ozr[0] = if0.zr; assign ong[0] = if0.ng; assign oco[0] = if0.co; assign oov[0] = if0.ov;

    assign if1.in_valid = iv[1];  assign if1.a = ia[1];       assign if1.b = ib[1];
    assign if1.zx = ictl[1][5];   assign if1.nx = ictl[1][4]; assign if1.zy = ictl[1][3];
    assign if1.ny = ictl[1][2];   assign if1.f  = ictl[1][1]; assign if1.no = ictl[1][0];
    assign if1.out_ready = ordy[1];
    assign irdy[1] = if1.in_ready; assign ovld[1] = if1.out_valid; assign oout[1] = if1.out;
    assign ozr[1] = if1.zr; assign ong[1] = if1.ng; assign oco[1] = if1.co; assign oov[1] = if1.ov;

    assign if2.in_valid = iv[2];  assign if2.a = ia[2][15:0]; assign if2.b = ib[2][15:0];
    assign if2.zx = ictl[2][5];   assign if2.nx = ictl[2][4]; assign if2.zy = ictl[2][3];
    assign if2.ny = ictl[2][2];   assign if2.f  = ictl[2][1]; assign if2.no = ictl[2][0];
    assign if2.out_ready = ordy[2];
    assign irdy[2] = if2.in_ready; assign ovld[2] = if2.out_valid; assign oout[2] = {16'd0, if2.out};
    assign ozr[2] = if2.zr; assign ong[2] = if2.ng; assign oco[2] = if2.co; assign oov[2] = if2.ov;

    function automatic int cfg_w(input int i);
        return (i == 1) ? 32 : 16;
    endfunction

    function automatic int cfg_c(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 16);
    endfunction

    // Hack ALU over w bits in plain integer arithmetic. fl = {zr,ng,co,ov}.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] c, output logic [31:0] o,
                                  output logic [3:0] fl);
        longint unsigned m, sb, x, y, s;
        logic co, ov;
        m  = (64'd1 << w) - 64'd1;
        sb = 64'd1 << (w - 1);
        x  = c[5] ? 64'd0 : ({32'd0, a} & m);
        if (c[4]) x = ~x & m;
        y  = c[3] ? 64'd0 : ({32'd0, b} & m);
        if (c[2]) y = ~y & m;
        co = 1'b0;
        ov = 1'b0;
        if (c[1]) begin
            s  = x + y;
            co = s[w];
            s  = s & m;
            ov = (((x & sb) != 0) == ((y & sb) != 0)) && (((s & sb) != 0) != ((x & sb) != 0));
        end else begin
            s = x & y;
        end
        if (c[0]) s = ~s & m;
        o  = s[31:0];
        fl = {s == 0, (s & sb) != 0, co, ov};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: tracks accept, completion time and expected result.
    always @(posedge clk) begin
        logic [31:0] mo;
        logic [3:0]  mf;
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                pend[i] <= 1'b0;
            end else if (pend[i]) begin
                if ((cyc - acc[i] >= elat[i]) && ordy[i]) pend[i] <= 1'b0;
            end else if (iv[i]) begin
                model(cfg_w(i), ia[i], ib[i], ictl[i], mo, mf);
                eo[i]   <= mo;
                ef[i]   <= mf;
                pend[i] <= 1'b1;
                acc[i]  <= cyc + 1;
                elat[i] <= ictl[i][1] ? cfg_w(i) / cfg_c(i) : 1;
            end
        end
    end

    // Compare every cycle: handshake always, result and flags while valid.
    always @(negedge clk) begin
        logic ev;
        for (int i = 0; i < 3; i++) begin
            if (rstn[i]) begin
                ev = pend[i] && (cyc - acc[i] >= elat[i]);
                chk($sformatf("u%0d_in_ready", i), {31'd0, irdy[i]}, {31'd0, !pend[i]});
                chk($sformatf("u%0d_out_valid", i), {31'd0, ovld[i]}, {31'd0, ev});
                if (ev) begin
                    chk($sformatf("u%0d_out", i), oout[i], eo[i]);
                    chk($sformatf("u%0d_flags", i), {28'd0, ozr[i], ong[i], oco[i], oov[i]},
                        {28'd0, ef[i]});
                end
            end
        end
    end

    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] c, input int stall,
                          output logic [31:0] o, output logic [3:0] fl, output int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!irdy[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        iv[i] = 1'b1; ia[i] = a; ib[i] = b; ictl[i] = c; ordy[i] = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!ovld[i] && lat < 100) begin
            iv[i]   = 1'($urandom_range(0, 1));
            ia[i]   = $urandom;
            ib[i]   = $urandom;
            ictl[i] = 6'($urandom);
            ordy[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        ordy[i] = 1'b0;
        repeat (stall) begin
            iv[i] = 1'($urandom_range(0, 1));
            ia[i] = $urandom;
            @(posedge clk); #1;
        end
        o  = oout[i];
        fl = {ozr[i], ong[i], oco[i], oov[i]};
        iv[i]   = 1'b0;
        ordy[i] = 1'b1;
        @(posedge clk); #1;
        ordy[i] = 1'b0;
        chk($sformatf("u%0d_latency", i), 32'(lat), 32'(c[1] ? cfg_w(i) / cfg_c(i) : 1));
    endtask

    function automatic logic [31:0] rv(input int w);
        logic [31:0] one;
        one = 32'd1;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return (one << (w - 1)) - one;
            3:       return one << (w - 1);
            4:       return one;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_ops(input int i, input int cnt);
        logic [31:0] o;
        logic [3:0]  fl;
        int          lat;
        for (int k = 0; k < cnt; k++) begin
            run_op(i, rv(cfg_w(i)), rv(cfg_w(i)), 6'($urandom), $urandom_range(0, 3), o, fl, lat);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] o;
        logic [3:0]  fl;
        int          lat;

        rstn = '0; iv = '0; ia = '0; ib = '0; ictl = '0; ordy = '0;

        // model pins: hand-computed Hack results
        model(16, 32'h7FFF, 32'h0001, 6'b000010, o, fl);
        chk("model_ovf_out", o, 32'h8000);      chk("model_ovf_fl", {28'd0, fl}, 32'h5);
        model(32, 32'hFFFF_FFFF, 32'h1, 6'b000010, o, fl);
        chk("model_wrap_out", o, 32'h0);        chk("model_wrap_fl", {28'd0, fl}, 32'hA);
        model(16, 32'h5, 32'h3, 6'b010011, o, fl);
        chk("model_sub_out", o, 32'h2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", oout[0], 32'h0);
        chk("rst_hs", {28'd0, irdy[0], ovld[0], ozr[0] | ong[0], oco[0] | oov[0]}, 32'h8);
        #2 rstn = 3'b111;

        run_op(0, 32'h0005, 32'h0003, 6'b000010, 0, o, fl, lat);
        chk("add_out", o, 32'h0008);   chk("add_fl", {28'd0, fl}, 32'h0);
        chk("add_lat", 32'(lat), 32'd4);
        run_op(0, 32'h7FFF, 32'h0001, 6'b000010, 0, o, fl, lat);
        chk("ovf_out", o, 32'h8000);   chk("ovf_fl", {28'd0, fl}, 32'h5);
        run_op(0, 32'hFFFF, 32'h0001, 6'b000010, 1, o, fl, lat);
        chk("wrap_out", o, 32'h0000);  chk("wrap_fl", {28'd0, fl}, 32'hA);
        run_op(0, 32'h0005, 32'h0003, 6'b010011, 0, o, fl, lat);
        chk("sub_out", o, 32'h0002);   chk("sub_fl", {28'd0, fl}, 32'h0);
        run_op(0, 32'h1234, 32'h5678, 6'b111010, 0, o, fl, lat);
        chk("neg1_out", o, 32'hFFFF);  chk("neg1_fl", {28'd0, fl}, 32'h4);
        run_op(0, 32'h0F0F, 32'h00FF, 6'b000000, 0, o, fl, lat);
        chk("and_out", o, 32'h000F);   chk("and_fl", {28'd0, fl}, 32'h0);
        chk("and_lat", 32'(lat), 32'd1);
        run_op(0, 32'h0005, 32'h0003, 6'b000010, 10, o, fl, lat);
        chk("stall_out", o, 32'h0008);

        // abort mid-CALC with a nonzero result still held from before
        @(posedge clk); #1;
        iv[0] = 1'b1; ia[0] = 32'h0101; ib[0] = 32'h0202; ictl[0] = 6'b000010;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #2;
        rstn[0] = 1'b0;
        #1;
        chk("abort_out", oout[0], 32'h0);
        chk("abort_hs", {28'd0, irdy[0], ovld[0], ozr[0] | ong[0], oco[0] | oov[0]}, 32'h8);
        @(posedge clk); #3;
        rstn[0] = 1'b1;
        run_op(0, 32'h0101, 32'h0202, 6'b000010, 0, o, fl, lat);
        chk("after_abort_out", o, 32'h0303);

        fork
            rand_ops(0, 200);
            rand_ops(1, 1000);
            rand_ops(2, 1000);
        join

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
